wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates three writeback sources onto the single 32-bit register-file write path: ALU, load unit and multiply unit.
- The write path is the 32-bit 3-to-1 select datapath.
- The block drives its 2-bit select and registers the winning beat into a one-entry output slot.
- It issues a valid/ready handshake to each source and to the register-file write port.

Parameters:
DW, 32, data width of each source and of wb_data
AW, 5, destination register index width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
src0_valid  input  1  ALU beat valid
src0_data  input  DW  ALU result
src0_rd  input  AW  ALU destination register
src0_ready  output  1  ALU beat accepted this cycle
src1_valid, src1_data, src1_rd, src1_ready  as src0, load unit
src2_valid, src2_data, src2_rd, src2_ready  as src0, multiply unit
wb_valid  output  1  output slot holds a beat
wb_data  output  DW  registered write data
wb_rd  output  AW  registered destination register
wb_sel  output  2  select of last accepted beat: 00 = src0, 01 = src1, 10 = src2; never 11
wb_ready  input  1  register-file port consumes the beat this cycle

Behaviour:
- Reset (async, rst_n low):
  - wb_valid = 0, wb_data = 0, wb_rd = 0, wb_sel = 00.
  - rr_last = 2, so src0 has first priority.
  - All srcN_ready deassert combinationally while rst_n is low.
- Output slot FSM has two states:
  - EMPTY (wb_valid = 0).
  - FULL (wb_valid = 1).
  - Slot is "free" when EMPTY, or when FULL and wb_ready = 1 (same-cycle drain and refill allowed).
- Grant:
  - Combinational each cycle.
  - Only when slot is free and at least one srcN_valid is set.
  - Exactly one srcN_ready = 1, to the winner. All others 0.
  - srcN_ready never asserts while srcN_valid = 0.
- Round-robin:
  - Search order starts at (rr_last+1) mod 3, then wraps.
  - On acceptance, rr_last <= winner index.
  - rr_last holds when nothing is accepted.
- Acceptance (valid & ready):
  - Next edge: wb_data <= srcN_data, wb_rd <= srcN_rd, wb_sel <= N, state FULL.
  - Latency: exactly 1 cycle from accept to wb_valid.
  - Throughput: 1 beat/cycle while wb_ready stays high.
- x0 drop:
  - A beat with srcN_rd == 0 is accepted (ready = 1) and rr_last updates.
  - The slot does not become FULL from it. If the slot was draining, it goes EMPTY.
  - wb_data, wb_rd and wb_sel keep their previous values.
- Drain:
  - FULL with wb_ready = 1 and no acceptance -> EMPTY next edge.
  - FULL with wb_ready = 0 -> hold all outputs stable and grant nothing (backpressure stalls all sources).
- Source rule: a source holds data/rd stable while valid and not ready. The arbiter does not check this.
- Reset mid-operation: a beat held in the slot is discarded. Sources re-present after reset.
- wb_sel changes only on acceptance of a non-x0 beat.

Optional Feature:
WB_FIXED_PRIO_EN
- Defined:
  - Fixed priority src0 > src1 > src2.
  - rr_last is not implemented.
  - Starvation of src2 under continuous src0 traffic is permitted.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset then single source: src1_valid, data=0x0000_00AA, rd=3, wb_ready=1.
   - Next cycle: src1_ready=1.
   - Following cycle: wb_valid=1, wb_data=0xAA, wb_rd=3, wb_sel=01.
2. All three valid continuously, rd=1/2/3, data 0x11/0x22/0x33, wb_ready=1.
   - Grant order src0, src1, src2, src0 on consecutive cycles.
   - wb_sel sequence 00, 01, 10, 00.
   - With WB_FIXED_PRIO_EN: src0 only.
3. Backpressure: slot FULL with 0x11, wb_ready=0 for 4 cycles, src2_valid high.
   - No ready asserted; wb_data stays 0x11.
   - wb_ready=1 -> src2 accepted same cycle; wb_data=0x33 next cycle with no bubble.
4. x0 write: src0_valid, rd=0, data=0xDEAD_BEEF.
   - src0_ready=1; wb_valid stays 0; wb_data unchanged.
   - rr_last=0, so next contested grant goes to src1.
5. Reset mid-stream: slot FULL, rst_n low for 1 cycle between edges.
   - Outputs 0 immediately; wb_sel=00.
   - After release, the first contested grant goes to src0.
6. Idle: no valids for 10 cycles after a drain.
   - wb_valid=0; all ready=0; wb_sel holds its last value.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: three sources (ALU, load, multiply) share one
// register-file write path through a one-entry registered output slot.
// Default build arbitrates round-robin; define WB_FIXED_PRIO_EN for fixed
// priority src0 > src1 > src2 (no round-robin pointer).
// Beats addressed to x0 are accepted but never enter the slot.
module wb_port_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          src0_valid,
    input  logic [DW-1:0] src0_data,
    input  logic [AW-1:0] src0_rd,
    output logic          src0_ready,
    input  logic          src1_valid,
    input  logic [DW-1:0] src1_data,
    input  logic [AW-1:0] src1_rd,
    output logic          src1_ready,
    input  logic          src2_valid,
    input  logic [DW-1:0] src2_data,
    input  logic [AW-1:0] src2_rd,
    output logic          src2_ready,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [AW-1:0] wb_rd,
    output logic [1:0]    wb_sel,
    input  logic          wb_ready
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [1:0]    sel_q, sel_d;

    logic [2:0]    valid_vec;
    logic [2:0]    ready_vec;
    logic [1:0]    win_idx;
    logic [DW-1:0] win_data;
    logic [AW-1:0] win_rd;
    logic          slot_free;
    logic          accept;
    logic          drop;

    assign valid_vec = {src2_valid, src1_valid, src0_valid};
    // A full slot is free when it drains this same cycle.
    assign slot_free = (state_q == StEmpty) || wb_ready;
    // rst_n gating keeps every ready low while reset is asserted.
    assign accept    = rst_n && slot_free && (|valid_vec);

`ifdef WB_FIXED_PRIO_EN
    // Fixed-priority winner select: lowest index wins.
    always_comb begin
        win_idx = 2'd2;
        if (src1_valid) win_idx = 2'd1;
        if (src0_valid) win_idx = 2'd0;
    end
`else
    logic [1:0] rr_last_q, rr_last_d;

    // Round-robin winner select, searching from the source after rr_last.
    always_comb begin
        win_idx = 2'd0;
        case (rr_last_q)
            2'd0: begin
                if (src1_valid)      win_idx = 2'd1;
                else if (src2_valid) win_idx = 2'd2;
                else                 win_idx = 2'd0;
            end
            2'd1: begin
                if (src2_valid)      win_idx = 2'd2;
                else if (src0_valid) win_idx = 2'd0;
                else                 win_idx = 2'd1;
            end
            default: begin
                if (src0_valid)      win_idx = 2'd0;
                else if (src1_valid) win_idx = 2'd1;
                else                 win_idx = 2'd2;
            end
        endcase
    end

    assign rr_last_d = accept ? win_idx : rr_last_q;

    // Round-robin pointer; reset to 2 so src0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 2'd2;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // One-hot ready to the winner only.
    always_comb begin
        ready_vec = 3'b000;
        if (accept) ready_vec[win_idx] = 1'b1;
    end

    assign src0_ready = ready_vec[0];
    assign src1_ready = ready_vec[1];
    assign src2_ready = ready_vec[2];

    // Winning beat datapath mux.
    always_comb begin
        win_data = src0_data;
        win_rd   = src0_rd;
        case (win_idx)
            2'd1: begin
                win_data = src1_data;
                win_rd   = src1_rd;
            end
            2'd2: begin
                win_data = src2_data;
                win_rd   = src2_rd;
            end
            default: begin
                win_data = src0_data;
                win_rd   = src0_rd;
            end
        endcase
    end

    assign drop = (win_rd == '0);

    // Slot next state: load on a non-x0 accept, otherwise drain or hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rd_d    = rd_q;
        sel_d   = sel_q;
        if (accept && !drop) begin
            state_d = StFull;
            data_d  = win_data;
            rd_d    = win_rd;
            sel_d   = win_idx;
        end else if ((state_q == StFull) && wb_ready) begin
            state_d = StEmpty;
        end
    end

    // Output slot registers; a held beat is discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            rd_q    <= '0;
            sel_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            sel_q   <= sel_d;
        end
    end

    assign wb_valid = (state_q == StFull);
    assign wb_data  = data_q;
    assign wb_rd    = rd_q;
    assign wb_sel   = sel_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default round-robin build): a
// cycle-by-cycle vector table plus hand-written reset sequences.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        src0_valid, src1_valid, src2_valid;
    logic [31:0] src0_data, src1_data, src2_data;
    logic [4:0]  src0_rd, src1_rd, src2_rd;
    logic        src0_ready, src1_ready, src2_ready;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;
    logic        wb_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DW(32), .AW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src0_valid (src0_valid),
        .src0_data  (src0_data),
        .src0_rd    (src0_rd),
        .src0_ready (src0_ready),
        .src1_valid (src1_valid),
        .src1_data  (src1_data),
        .src1_rd    (src1_rd),
        .src1_ready (src1_ready),
        .src2_valid (src2_valid),
        .src2_data  (src2_data),
        .src2_rd    (src2_rd),
        .src2_ready (src2_ready),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_sel     (wb_sel),
        .wb_ready   (wb_ready)
    );

    // One row = inputs held for a cycle and the outputs expected just before
    // the closing edge (readys combinational, wb_* from the previous edge).
    typedef struct {
        logic [2:0]  v;
        logic        wr;
        logic [31:0] d0;
        logic [4:0]  r0;
        logic [31:0] d1;
        logic [4:0]  r1;
        logic [2:0]  erdy;
        logic        ewv;
        logic [31:0] ewd;
        logic [4:0]  ewr;
        logic [1:0]  ews;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] v, input logic wr,
                                input logic [31:0] d0, input logic [4:0] r0,
                                input logic [31:0] d1, input logic [4:0] r1,
                                input logic [2:0] erdy, input logic ewv,
                                input logic [31:0] ewd, input logic [4:0] ewr,
                                input logic [1:0] ews);
        vec_t r;
        r.v = v; r.wr = wr; r.d0 = d0; r.r0 = r0; r.d1 = d1; r.r1 = r1;
        r.erdy = erdy; r.ewv = ewv; r.ewd = ewd; r.ewr = ewr; r.ews = ews;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] erdy, input logic ewv,
                           input logic [31:0] ewd, input logic [4:0] ewr,
                           input logic [1:0] ews);
        chk({tag, " ready"},  {29'd0, src2_ready, src1_ready, src0_ready}, {29'd0, erdy});
        chk({tag, " wb_valid"}, {31'd0, wb_valid}, {31'd0, ewv});
        chk({tag, " wb_data"},  wb_data, ewd);
        chk({tag, " wb_rd"},    {27'd0, wb_rd}, {27'd0, ewr});
        chk({tag, " wb_sel"},   {30'd0, wb_sel}, {30'd0, ews});
    endtask

    initial begin
        // Reset: everything low, readys gated even with all sources valid.
        rst_n      = 1'b0;
        wb_ready   = 1'b1;
        src0_valid = 1'b1; src0_data = 32'h11; src0_rd = 5'd1;
        src1_valid = 1'b1; src1_data = 32'h22; src1_rd = 5'd2;
        src2_valid = 1'b1; src2_data = 32'h33; src2_rd = 5'd3;
        #3;
        chk_all("reset", 3'b000, 1'b0, 32'h0, 5'd0, 2'b00);
        src0_valid = 1'b0; src1_valid = 1'b0; src2_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: single load-unit beat, then drain and idle.
        vecs.push_back(mk(3'b010, 1, 32'h11, 5'd1, 32'hAA, 5'd3, 3'b010, 0, 32'h00, 5'd0, 2'b00));
        vecs.push_back(mk(3'b000, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b000, 1, 32'hAA, 5'd3, 2'b01));
        vecs.push_back(mk(3'b000, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b000, 0, 32'hAA, 5'd3, 2'b01));
        // src2 alone moves rr_last to 2 so the next contest starts at src0.
        vecs.push_back(mk(3'b100, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b100, 0, 32'hAA, 5'd3, 2'b01));
        // Test 2: all valid, rotating grants with 1 beat/cycle.
        vecs.push_back(mk(3'b111, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b001, 1, 32'h33, 5'd3, 2'b10));
        vecs.push_back(mk(3'b111, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b010, 1, 32'h11, 5'd1, 2'b00));
        vecs.push_back(mk(3'b111, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b100, 1, 32'h22, 5'd2, 2'b01));
        vecs.push_back(mk(3'b111, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b001, 1, 32'h33, 5'd3, 2'b10));
        // Test 3: backpressure with src2 waiting, then same-cycle refill.
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(3'b100, 0, 32'h11, 5'd1, 32'h22, 5'd2, 3'b000, 1, 32'h11, 5'd1, 2'b00));
        vecs.push_back(mk(3'b100, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b100, 1, 32'h11, 5'd1, 2'b00));
        vecs.push_back(mk(3'b000, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b000, 1, 32'h33, 5'd3, 2'b10));
        // Test 4: x0 beat accepted into an empty slot and dropped.
        vecs.push_back(mk(3'b001, 1, 32'hDEADBEEF, 5'd0, 32'h22, 5'd2, 3'b001, 0, 32'h33, 5'd3, 2'b10));
        vecs.push_back(mk(3'b000, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b000, 0, 32'h33, 5'd3, 2'b10));
        vecs.push_back(mk(3'b111, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b010, 0, 32'h33, 5'd3, 2'b10));
        // x0 beat while the slot drains: slot goes empty, data kept.
        vecs.push_back(mk(3'b001, 1, 32'hDEADBEEF, 5'd0, 32'h22, 5'd2, 3'b001, 1, 32'h22, 5'd2, 2'b01));
        // Test 6: idle for 10 cycles after drain.
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(3'b000, 1, 32'h11, 5'd1, 32'h22, 5'd2, 3'b000, 0, 32'h22, 5'd2, 2'b01));

        for (int i = 0; i < vecs.size(); i++) begin
            {src2_valid, src1_valid, src0_valid} = vecs[i].v;
            wb_ready  = vecs[i].wr;
            src0_data = vecs[i].d0; src0_rd = vecs[i].r0;
            src1_data = vecs[i].d1; src1_rd = vecs[i].r1;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].erdy, vecs[i].ewv, vecs[i].ewd,
                    vecs[i].ewr, vecs[i].ews);
            @(posedge clk);
            #1;
        end

        // Test 5: fill the slot under backpressure, then pulse reset between edges.
        src0_data = 32'h11; src0_rd = 5'd1;
        src1_data = 32'h22; src1_rd = 5'd2;
        {src2_valid, src1_valid, src0_valid} = 3'b010;
        wb_ready = 1'b0;
        @(negedge clk);
        chk_all("fill", 3'b010, 1'b0, 32'h22, 5'd2, 2'b01);
        @(posedge clk);
        #1;
        {src2_valid, src1_valid, src0_valid} = 3'b000;
        #1;
        chk_all("full", 3'b000, 1'b1, 32'h22, 5'd2, 2'b01);
        rst_n = 1'b0;
        {src2_valid, src1_valid, src0_valid} = 3'b111;
        #1;
        chk_all("midrst", 3'b000, 1'b0, 32'h0, 5'd0, 2'b00);
        #3;
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        #1;
        chk_all("postrst", 3'b001, 1'b0, 32'h0, 5'd0, 2'b00);
        @(posedge clk);
        #1;
        {src2_valid, src1_valid, src0_valid} = 3'b000;
        #1;
        chk_all("postrst_wb", 3'b000, 1'b1, 32'h11, 5'd1, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
